// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: grant/state encodings and bus constants shared by the data-memory arbiter
package dmem_arbiter_pkg;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CORE = 2'b01;
  localparam logic [1:0] GNT_UART = 2'b10;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
  typedef enum logic [1:0] {
    IDLE     = GNT_NONE,
    CORE_BUS = GNT_CORE,
    UART_BUS = GNT_UART
  } state_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick; ports req_core/req_uart/last_uart in, one-hot gnt {uart,core} out
module rr_arb2 (
  input  logic       req_core,
  input  logic       req_uart,
  input  logic       last_uart,
  output logic [1:0] gnt
);
  logic uart_win;
  assign uart_win = req_uart & (~req_core | ~last_uart);
  assign gnt = {uart_win, req_core & ~uart_win};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data memory between core (i_core_*) and UART bridge (i_uart_*) onto o_mem_*/i_mem_*, with grant, stall and watchdog (o_timeout_err)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [ADDR_WIDTH-1:0] i_core_adr,
  input  logic [DATA_WIDTH-1:0] i_core_dat,
  input  logic [2:0]            i_core_funct3,
  output logic [DATA_WIDTH-1:0] o_core_dat,
  output logic                  o_core_ack,
  output logic                  o_core_stall,
  input  logic                  i_uart_cyc,
  input  logic                  i_uart_stb,
  input  logic                  i_uart_we,
  input  logic [ADDR_WIDTH-1:0] i_uart_adr,
  input  logic [DATA_WIDTH-1:0] i_uart_dat,
  output logic [DATA_WIDTH-1:0] o_uart_dat,
  output logic                  o_uart_ack,
  output logic                  o_mem_cyc,
  output logic                  o_mem_stb,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_adr,
  output logic [DATA_WIDTH-1:0] o_mem_dat,
  output logic [2:0]            o_mem_funct3,
  input  logic [DATA_WIDTH-1:0] i_mem_dat,
  input  logic                  i_mem_ack,
  output logic [1:0]            o_grant,
  output logic                  o_timeout_err
);
  state_t state, state_nx;
  logic cyc, cyc_nx, we, we_nx, last_uart, last_uart_nx, err, err_nx;
  logic [ADDR_WIDTH-1:0] adr, adr_nx;
  logic [DATA_WIDTH-1:0] dat, dat_nx;
  logic [2:0] f3, f3_nx;
  logic [15:0] cnt, cnt_nx;
  logic [1:0] gnt;
  logic timeout, ack, done;
  rr_arb2 u_rr (
    .req_core (i_core_req),
    .req_uart (i_uart_cyc & i_uart_stb),
    .last_uart(last_uart),
    .gnt      (gnt)
  );
  // watchdog fires as a synthetic ack carrying zero data
  assign timeout = (state != IDLE) && (cnt == 16'(TIMEOUT_CYCLES));
  assign ack = i_mem_ack | timeout;
  // a UART master dropping cyc abandons its access without an ack
  assign done = ack | (state == UART_BUS && !i_uart_cyc);
  assign o_core_ack = (state == CORE_BUS) & ack;
  assign o_uart_ack = (state == UART_BUS) & ack;
  assign o_core_dat = (state == CORE_BUS && !timeout) ? i_mem_dat : '0;
  assign o_uart_dat = (state == UART_BUS && !timeout) ? i_mem_dat : '0;
  assign o_core_stall = i_core_req & ~o_core_ack;
  assign o_mem_cyc = cyc;
  assign o_mem_stb = cyc;
  assign o_mem_we = we;
  assign o_mem_adr = adr;
  assign o_mem_dat = dat;
  assign o_mem_funct3 = f3;
  assign o_grant = state;
  assign o_timeout_err = err;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc <= 1'b0;
      we <= 1'b0;
      adr <= '0;
      dat <= '0;
      f3 <= '0;
      cnt <= '0;
      err <= 1'b0;
      last_uart <= 1'b0;
    end else begin
      state <= state_nx;
      cyc <= cyc_nx;
      we <= we_nx;
      adr <= adr_nx;
      dat <= dat_nx;
      f3 <= f3_nx;
      cnt <= cnt_nx;
      err <= err_nx;
      last_uart <= last_uart_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cyc_nx = cyc;
    we_nx = we;
    adr_nx = adr;
    dat_nx = dat;
    f3_nx = f3;
    cnt_nx = cnt + 16'd1;
    err_nx = err | timeout;
    last_uart_nx = last_uart;
    if (state == IDLE) begin
      cnt_nx = '0;
      if (|gnt) begin
        state_nx = gnt[1] ? UART_BUS : CORE_BUS;
        cyc_nx = 1'b1;
        we_nx = gnt[1] ? i_uart_we : i_core_we;
        adr_nx = gnt[1] ? i_uart_adr : i_core_adr;
        dat_nx = gnt[1] ? i_uart_dat : i_core_dat;
        f3_nx = gnt[1] ? FUNCT3_WORD : i_core_funct3;
      end
    end else if (done) begin
      state_nx = IDLE;
      cyc_nx = 1'b0;
      we_nx = 1'b0;
      adr_nx = '0;
      dat_nx = '0;
      f3_nx = '0;
      cnt_nx = '0;
      last_uart_nx = (state == UART_BUS);
    end
  end
  core_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == CORE_BUS && !o_core_ack) |-> i_core_req);
endmodule
